gpioemu_host: RTL
=================

// Module: gpioemu_host
// PURPOSE
// Bus initiator for the gpioemu register interface: takes an (arg1, arg2) job, writes A1/A2, issues the
// start write, polls status, then reads result W and ones-count. Sits between a command source and
// gpioemu, driving saddress/srd/swr with strobes held whole clk cycles, as gpioemu registers on strobe edges.
// PARAMETERS
// SETUP_CYC   2        cycles address/write-data stable before strobe rises (>=1)
// STROBE_CYC  2        cycles srd/swr held high (>=1)
// HOLD_CYC    1        cycles address/data held after strobe falls (>=1)
// DONE_CODE   2'b11    status[1:0] value read at 0x03A0 meaning operation complete
// POLL_MAX    1023     poll reads before timeout (used only with GPIOEMU_HOST_TIMEOUT_EN)
// PORTS
// clk          in   1   system clock, all logic on posedge
// reset        in   1   synchronous, active-high
// cmd_valid    in   1   job request
// cmd_ready    out  1   high in IDLE only; job accepted when cmd_valid&cmd_ready
// cmd_arg1     in   24  value written to 0x037F
// cmd_arg2     in   24  value written to 0x0388
// rsp_valid    out  1   response held until rsp_ready
// rsp_ready    in   1   response consumer ready
// rsp_result   out  32  data read from 0x0390
// rsp_ones     out  24  data[23:0] read from 0x0398
// rsp_timeout  out  1   job aborted by poll timeout (0 when feature compiled out)
// busy         out  1   state != IDLE
// saddress     out  16  bus address to gpioemu
// srd          out  1   read strobe
// swr          out  1   write strobe
// sdata_wr     out  32  write data (to gpioemu sdata_in)
// sdata_rd     in   32  read data (from gpioemu sdata_out)
// BEHAVIOUR
// - Reset: outputs 0 except cmd_ready=1; saddress=0, srd=swr=0, sdata_wr=0; state IDLE; counters 0.
// - Reset mid-job takes priority the same cycle: strobes drop at once, partial job discarded, no response.
// - Accept: cmd args captured into internal regs; later changes on cmd_* ignored until next accept.
// - FSM: IDLE -> WR_A1(0x037F,{8'h0,arg1}) -> WR_A2(0x0388,{8'h0,arg2}) -> WR_GO(0x03A0,32'h0)
//   -> POLL(rd 0x03A0) -> RD_W(rd 0x0390) -> RD_CNT(rd 0x0398) -> RESP -> IDLE.
// - Each bus op: SETUP phase (addr/data driven, strobes 0) SETUP_CYC cycles, STROBE phase STROBE_CYC
//   cycles, HOLD phase HOLD_CYC cycles. srd and swr never high together; never both high in one op.
// - Read capture: sdata_rd sampled on the last STROBE-phase cycle (edge-triggered data settled).
// - POLL: if captured[1:0]==DONE_CODE go RD_W, else repeat POLL op back-to-back (new SETUP phase).
// - Bus op length = SETUP_CYC+STROBE_CYC+HOLD_CYC; defaults: 5 cycles; minimum job = 6 ops+1 = 31 cycles.
// - Between ops saddress keeps last value; sdata_wr returns to 0 after each write HOLD.
// - RESP: rsp_valid=1, outputs stable until rsp_valid&rsp_ready; then IDLE, cmd_ready=1 next cycle.
//   Same-cycle rsp_ready with rsp_valid rise completes in one cycle. No new job accepted while in RESP.
// - Phase counter width clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC)+1); poll counter clog2(POLL_MAX+1).
// CONFIGURATION
// GPIOEMU_HOST_TIMEOUT_EN defined: poll counter increments per completed POLL op; when it reaches
//   POLL_MAX without DONE_CODE, skip reads, go RESP with rsp_timeout=1, rsp_result=0, rsp_ones=0.
//   Counter cleared on accept. Not defined: POLL loops forever, rsp_timeout tied 0, no poll counter.
// TESTING
// 1 Reset: assert reset 3 cycles mid-WR_A2 -> srd=swr=0 next cycle, cmd_ready=1, rsp_valid=0.
// 2 Job arg1=24'h000005 arg2=24'h000003, model returns status 2'b11 first poll, W=32'h28, cnt=24'h1
//   -> write seq 037F/5, 0388/3, 03A0/0; reads 03A0,0390,0398; rsp_result=32'h28, rsp_ones=1, 31 cycles.
// 3 Model returns status 2'b00 4 times then 2'b11 -> exactly 5 POLL reads, then correct response.
// 4 Hold rsp_ready=0 for 10 cycles -> rsp_* stable, cmd_ready=0, no bus activity; release -> IDLE.
// 5 Timing check each op: strobe high exactly STROBE_CYC, addr stable SETUP_CYC before/HOLD_CYC after.
// 6 TIMEOUT_EN, POLL_MAX=4, status never 2'b11 -> 4 polls, rsp_timeout=1, result/ones 0, no W/cnt reads.

Source files
------------

// File: rtl/gpioemu_host.sv
// Bus initiator for gpioemu: writes A1/A2, starts the operation, polls status, reads W and ones-count.
// Optional poll timeout enabled by defining GPIOEMU_HOST_TIMEOUT_EN.
module gpioemu_host #(
  parameter int         SETUP_CYC  = 2,
  parameter int         STROBE_CYC = 2,
  parameter int         HOLD_CYC   = 1,
  parameter logic [1:0] DONE_CODE  = 2'b11,
  parameter int         POLL_MAX   = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_arg1,
  input  logic [23:0] cmd_arg2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [23:0] rsp_ones,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_wr,
  input  logic [31:0] sdata_rd
);

  localparam int PH_MAX = (SETUP_CYC > STROBE_CYC) ?
                          ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                          ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int PW = $clog2(PH_MAX + 1);

  localparam logic [15:0] ADDR_A1  = 16'h037F;
  localparam logic [15:0] ADDR_A2  = 16'h0388;
  localparam logic [15:0] ADDR_GO  = 16'h03A0;
  localparam logic [15:0] ADDR_W   = 16'h0390;
  localparam logic [15:0] ADDR_CNT = 16'h0398;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_A1, S_WR_A2, S_WR_GO, S_POLL, S_RD_W, S_RD_CNT, S_RESP
  } state_t;

  typedef enum logic [1:0] {
    P_SETUP, P_STROBE, P_HOLD
  } phase_t;

  state_t        r_state, w_state_next;
  phase_t        r_phase, w_phase_next;
  logic [PW-1:0] r_pcnt, w_pcnt_next;
  logic [PW-1:0] w_phase_last;

  logic [23:0] r_arg1, r_arg2;
  logic [15:0] r_saddress, w_saddress_next;
  logic [1:0]  r_status;
  logic [31:0] r_result;
  logic [23:0] r_ones;

  logic w_is_read, w_is_write, w_in_op;
  logic w_phase_end, w_op_end, w_capture, w_accept, w_poll_done;
  logic w_timeout_hit;

  // Operation classification and phase bookkeeping for the current bus op
  always_comb begin
    w_is_read  = (r_state == S_POLL) || (r_state == S_RD_W) || (r_state == S_RD_CNT);
    w_is_write = (r_state == S_WR_A1) || (r_state == S_WR_A2) || (r_state == S_WR_GO);
    w_in_op    = w_is_read || w_is_write;
    case (r_phase)
      P_SETUP:  w_phase_last = PW'(SETUP_CYC - 1);
      P_STROBE: w_phase_last = PW'(STROBE_CYC - 1);
      default:  w_phase_last = PW'(HOLD_CYC - 1);
    endcase
    w_phase_end = w_in_op && (r_pcnt == w_phase_last);
    w_op_end    = w_phase_end && (r_phase == P_HOLD);
    // Read data is sampled at the end of the strobe, after gpioemu has reacted to the rising edge
    w_capture   = w_is_read && w_phase_end && (r_phase == P_STROBE);
    w_accept    = cmd_valid && (r_state == S_IDLE);
    w_poll_done = (r_status == DONE_CODE);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_next = S_WR_A1;
      S_WR_A1:  if (w_op_end) w_state_next = S_WR_A2;
      S_WR_A2:  if (w_op_end) w_state_next = S_WR_GO;
      S_WR_GO:  if (w_op_end) w_state_next = S_POLL;
      S_POLL: begin
        if (w_op_end) begin
          if (w_poll_done)        w_state_next = S_RD_W;
          else if (w_timeout_hit) w_state_next = S_RESP;
          else                    w_state_next = S_POLL;
        end
      end
      S_RD_W:   if (w_op_end) w_state_next = S_RD_CNT;
      S_RD_CNT: if (w_op_end) w_state_next = S_RESP;
      S_RESP:   if (rsp_ready) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_phase_next = r_phase;
    w_pcnt_next  = '0;
    if (w_accept || w_op_end || !w_in_op) begin
      w_phase_next = P_SETUP;
    end else if (w_phase_end) begin
      w_phase_next = (r_phase == P_SETUP) ? P_STROBE : P_HOLD;
    end else begin
      w_pcnt_next = r_pcnt + 1'b1;
    end
  end

  // Address is latched on op entry and kept while idle or waiting on the response
  always_comb begin
    w_saddress_next = r_saddress;
    case (w_state_next)
      S_WR_A1:  w_saddress_next = ADDR_A1;
      S_WR_A2:  w_saddress_next = ADDR_A2;
      S_WR_GO:  w_saddress_next = ADDR_GO;
      S_POLL:   w_saddress_next = ADDR_GO;
      S_RD_W:   w_saddress_next = ADDR_W;
      S_RD_CNT: w_saddress_next = ADDR_CNT;
      default:  w_saddress_next = r_saddress;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_phase    <= P_SETUP;
      r_pcnt     <= '0;
      r_saddress <= '0;
    end else begin
      r_state    <= w_state_next;
      r_phase    <= w_phase_next;
      r_pcnt     <= w_pcnt_next;
      r_saddress <= w_saddress_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_arg1   <= '0;
      r_arg2   <= '0;
      r_status <= '0;
      r_result <= '0;
      r_ones   <= '0;
    end else if (w_accept) begin
      r_arg1   <= cmd_arg1;
      r_arg2   <= cmd_arg2;
      r_status <= '0;
      r_result <= '0;
      r_ones   <= '0;
    end else if (w_capture) begin
      case (r_state)
        S_POLL:   r_status <= sdata_rd[1:0];
        S_RD_W:   r_result <= sdata_rd;
        S_RD_CNT: r_ones   <= sdata_rd[23:0];
        default:  r_status <= r_status;
      endcase
    end
  end

`ifdef GPIOEMU_HOST_TIMEOUT_EN
  localparam int PCW = $clog2(POLL_MAX + 1);

  logic [PCW-1:0] r_poll_cnt;
  logic           r_timeout;

  // The completing poll is the one that brings the count up to POLL_MAX
  assign w_timeout_hit = (r_poll_cnt == PCW'(POLL_MAX - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_poll_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_accept) begin
      r_poll_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if ((r_state == S_POLL) && w_op_end && !w_poll_done) begin
      r_poll_cnt <= r_poll_cnt + 1'b1;
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end

  assign rsp_timeout = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign rsp_timeout   = 1'b0;
`endif

  // Strobes are gated by reset so a mid-job reset drops them without waiting for the edge
  assign srd       = w_is_read  && (r_phase == P_STROBE) && !reset;
  assign swr       = w_is_write && (r_phase == P_STROBE) && !reset;
  assign saddress  = r_saddress;
  assign sdata_wr  = (r_state == S_WR_A1) ? {8'h00, r_arg1} :
                     (r_state == S_WR_A2) ? {8'h00, r_arg2} : 32'h0;
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_result = r_result;
  assign rsp_ones   = r_ones;

endmodule
